mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, instr).
- Lets the CPU core (master 0) share the on-chip RAM / output-port slave with a second requester (master 1: loader, DMA or debug port).
- Round-robin grant, with the grant held for a whole transaction.
- Per-transaction watchdog: completes a hung access with a fixed read value and records the failing address.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a granted access may wait for s_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on forced completion.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- m0_valid, m1_valid  in  1  master request
- m0_instr, m1_instr  in  1  instruction-fetch qualifier
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read
- m0_ready, m1_ready  out  1  transaction-complete pulse to master
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high
- s_valid  out  1  request to slave
- s_instr  out  1  forwarded instr qualifier
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded write strobes
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = idle
- timeout_err  out  1  sticky watchdog flag
- timeout_addr  out  32  address of the first timed-out access
- timeout_clr  in  1  clears timeout_err

Behaviour:
- FSM states: IDLE, G0, G1.
- Reset (resetn low at a clk edge, from any state, including mid-transaction):
  - state = IDLE, last_grant = 1 (so m0 wins the first tie).
  - Watchdog counter = 0, timeout_err = 0, timeout_addr = 0.
  - All ready, valid and grant outputs are 0; s_* and m*_rdata are 0.
  - An aborted slave access is dropped; no ready is issued.
- IDLE:
  - Only m0_valid high -> G0. Only m1_valid high -> G1.
  - Both high -> the master not equal to last_grant.
  - Neither high -> stay in IDLE.
  - Arbitration costs exactly one cycle; s_valid is 0 in IDLE.
- Gx (x = granted master):
  - s_valid = mx_valid. s_addr, s_wdata, s_wstrb and s_instr are a combinational mux of master x's signals.
  - grant[x] = 1.
  - On s_ready = 1: mx_ready = 1 and mx_rdata = s_rdata in the same cycle (zero added latency). Next state is IDLE and last_grant = x.
- Minimum request-to-ready latency is 1 (arbitration) + slave latency. Back-to-back transactions from one master have one IDLE bubble; a waiting master therefore always wins the next IDLE (fairness).
- Non-granted master: ready = 0 and rdata = 0 at all times.
- The granted master dropping valid before ready is a protocol violation: return to IDLE next cycle, issue no ready, leave last_grant unchanged.
- s_ready while in IDLE is ignored.
- Watchdog:
  - Counter clears on entry to Gx and increments each Gx cycle with s_ready = 0.
  - When the counter equals TIMEOUT_CYCLES (parameter nonzero):
    - mx_ready = 1 and mx_rdata = ERR_RDATA; s_valid is forced to 0 that cycle.
    - Next state is IDLE and last_grant = x.
    - timeout_err is set; timeout_addr captures s_addr only if timeout_err was 0.
  - If s_ready and the timeout coincide, s_ready wins: normal completion, no error.
- timeout_clr clears timeout_err on the next edge; a simultaneous new timeout takes priority (flag stays set). timeout_addr persists until reset.
- Writes (wstrb != 0) return whatever the slave drives on s_rdata; the arbiter does not qualify rdata.

Test Plan:
- Single m0 read, addr 0x100, slave ready 1 cycle after s_valid:
  - grant = 01 one cycle after m0_valid.
  - m0_ready pulses with m0_rdata = s_rdata (0x12345678).
  - m1 outputs stay 0.
- m0 and m1 both asserting valid continuously for 6 transactions: grants alternate 01, 10, 01, ... starting with m0, with one IDLE cycle between grants.
- m1 write 0x1000_0000, wdata 0x41, wstrb 0001, concurrent with an m0 fetch (instr = 1), m1 requesting first:
  - s_* carries m1's fields exactly.
  - s_instr = 0 during m1's grant, 1 during m0's.
- Slave never responds, TIMEOUT_CYCLES = 4, m0 read at 0x2000:
  - m0_ready after 4 stalled cycles with rdata 0xDEADBEEF.
  - timeout_err = 1, timeout_addr = 0x2000.
  - A second timeout at 0x3000 leaves timeout_addr = 0x2000.
  - timeout_clr -> timeout_err = 0.
- s_ready arrives on the exact timeout cycle -> normal rdata, timeout_err stays 0.
- resetn low mid-G1 with s_ready pending:
  - Next cycle grant = 00 and all outputs 0; no ready pulse.
  - After release, simultaneous requests grant m0 first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// mem_bus_arbiter: round-robin two-master arbiter for the PicoRV32 native memory
// bus with a per-transaction watchdog.  Rev 1.0
module mem_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [31:0] timeout_addr,
  input  logic        timeout_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic        gnt0, gnt1, sel_valid, wd_hit;
  logic        done_ok, done_to, done;
  logic [31:0] rd_sel;

  // Outputs are gated by resetn so an access in flight during reset never completes.
  always_comb begin
    gnt0      = resetn && (state_q == G0);
    gnt1      = resetn && (state_q == G1);
    sel_valid = (gnt0 && m0_valid) || (gnt1 && m1_valid);
    wd_hit    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX);
    done_ok   = sel_valid && s_ready;
    done_to   = sel_valid && !s_ready && wd_hit;
    done      = done_ok || done_to;
    rd_sel    = done_ok ? s_rdata : ERR_RDATA;
  end

  always_comb begin
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (gnt0) begin
      s_instr = m0_instr;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (gnt1) begin
      s_instr = m1_instr;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end
  end

  assign s_valid      = sel_valid && !done_to;
  assign grant        = {gnt1, gnt0};
  assign m0_ready     = gnt0 && done;
  assign m1_ready     = gnt1 && done;
  assign m0_rdata     = m0_ready ? rd_sel : '0;
  assign m1_rdata     = m1_ready ? rd_sel : '0;
  assign timeout_err  = err_q;
  assign timeout_addr = err_addr_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = '0;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not own the last transaction wins.
        if (m0_valid && m1_valid) state_d = last_q ? G0 : G1;
        else if (m0_valid)        state_d = G0;
        else if (m1_valid)        state_d = G1;
      end
      G0, G1: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          last_d  = (state_q == G1);
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_to) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = s_addr;
    end else if (timeout_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
`default_nettype wire
